// File: rtl/led_status_arbiter.sv
// Status-LED arbiter: fixed-priority owner with minimum hold time, blink ticks, per-requester pattern decode.
// Optional: define LED_ARB_PREEMPT_EN to let a higher-priority req preempt while the hold timer is running.

module led_pattern_dec (
  input  logic [2:0] mode,
  input  logic       blink,
  output logic       green,
  output logic       red
);
  always_comb begin
    green = 1'b0;
    red   = 1'b0;
    case (mode)
      3'd1: green = 1'b1;
      3'd2: red   = 1'b1;
      3'd3: green = blink;
      3'd4: red   = blink;
      3'd5: begin green = ~blink; red = blink; end
      3'd6: begin green = 1'b1;   red = 1'b1;  end
      default: ;
    endcase
  end
endmodule

module led_status_arbiter #(
  parameter real CLK_FREQUENCY = 65.0e6,
  parameter real TICK_PERIOD   = 0.125,
  parameter int  NUM_REQ       = 4,
  parameter int  HOLD_TICKS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   mode,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   led_green,
  output logic                   led_red,
  output logic                   led_blue,
  output logic                   tick
);
  localparam int TICK_COUNT = $rtoi(CLK_FREQUENCY * TICK_PERIOD + 0.5);
  localparam int CW = $clog2(TICK_COUNT);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

`ifdef LED_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic [CW-1:0] cnt;
  logic [2:0]    phase;
  logic          blink;
  logic [0:0]    state, nxt_state;
  logic [IW-1:0] owner, nxt_owner;
  logic [HW-1:0] hold, nxt_hold;
  logic          lo_any, hp_any;
  logic [IW-1:0] lo_idx;
  logic [NUM_REQ-1:0] dec_g, dec_r;

  assign blink = phase[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      tick  <= 1'b0;
      phase <= '0;
    end else begin
      cnt   <= (cnt == CW'(TICK_COUNT - 1)) ? '0 : cnt + 1'b1;
      tick  <= (cnt == CW'(TICK_COUNT - 1));
      if (tick) phase <= phase + 3'd1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_dec
      led_pattern_dec u_dec (
        .mode  (mode[3*g +: 3]),
        .blink (blink),
        .green (dec_g[g]),
        .red   (dec_r[g])
      );
    end
  endgenerate

  // Lowest asserted index; it is also the only possible higher-priority candidate.
  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        lo_any = 1'b1;
        lo_idx = IW'(i);
      end
  end

  assign hp_any = lo_any && (state == S_GRANT) && (lo_idx < owner);

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_hold  = hold;
    if (tick && hold != '0) nxt_hold = hold - 1'b1;
    if (state == S_IDLE) begin
      if (lo_any) begin
        nxt_state = S_GRANT;
        nxt_owner = lo_idx;
        nxt_hold  = HW'(HOLD_TICKS);
      end
    end else begin
      if (hp_any && (hold == '0 || PREEMPT)) begin
        nxt_owner = lo_idx;
        nxt_hold  = HW'(HOLD_TICKS);
      end else if (hold != '0 || req[owner]) begin
        nxt_owner = owner;
      end else if (lo_any) begin
        nxt_owner = lo_idx;
        nxt_hold  = HW'(HOLD_TICKS);
      end else begin
        nxt_state = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      hold      <= '0;
      grant     <= '0;
      led_green <= 1'b0;
      led_red   <= 1'b0;
      led_blue  <= 1'b0;
    end else begin
      state <= nxt_state;
      owner <= nxt_owner;
      hold  <= nxt_hold;
      if (nxt_state == S_GRANT) begin
        grant     <= NUM_REQ'(1) << nxt_owner;
        led_green <= dec_g[nxt_owner];
        led_red   <= dec_r[nxt_owner];
        led_blue  <= 1'b1;
      end else begin
        grant     <= '0;
        led_green <= 1'b0;
        led_red   <= 1'b0;
        led_blue  <= blink;
      end
    end
  end
endmodule

// File: tb/tb_led_status_arbiter.sv
// Randomized + scenario bench for led_status_arbiter against a tick-count based reference model.
module tb_led_status_arbiter;
  localparam int NR   = 4;
  localparam int HOLD = 8;
  localparam int TC   = 10;
`ifdef LED_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [3*NR-1:0] mode;
  logic [NR-1:0] grant;
  logic          led_green, led_red, led_blue, tick;

  int n_run = 0;
  int n_fail = 0;

  // model state: edges since reset release, owner (-1 idle), tick total at grant
  int E, m_own, m_gT;
  logic [NR-1:0] exp_grant;
  logic exp_g, exp_r, exp_b, exp_t;

  led_status_arbiter #(
    .CLK_FREQUENCY(1000.0), .TICK_PERIOD(0.01), .NUM_REQ(NR), .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .grant(grant),
    .led_green(led_green), .led_red(led_red), .led_blue(led_blue), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, E);
    end
  endtask

  // ticks consumed by the hold/phase logic after e edges
  function automatic int ticks(input int e);
    return (e >= 1) ? (e - 1) / TC : 0;
  endfunction

  task automatic model_edge();
    int tp, tn, lo;
    bit held, blink;
    logic [2:0] m;
    tp = ticks(E);
    E++;
    tn = ticks(E);
    held = (m_own >= 0) && ((tp - m_gT) < HOLD);
    lo = -1;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) lo = i;
    if (m_own < 0) begin
      if (lo >= 0) begin m_own = lo; m_gT = tn; end
    end else if (lo >= 0 && lo < m_own && (!held || PRE)) begin
      m_own = lo; m_gT = tn;
    end else if (held || req[m_own]) begin
      m_own = m_own;
    end else if (lo >= 0) begin
      m_own = lo; m_gT = tn;
    end else begin
      m_own = -1;
    end
    blink = (tp % 8) >= 4;
    exp_t = (E >= TC) && (E % TC == 0);
    exp_g = 1'b0; exp_r = 1'b0;
    if (m_own < 0) begin
      exp_grant = '0;
      exp_b = blink;
    end else begin
      exp_grant = NR'(1 << m_own);
      exp_b = 1'b1;
      m = mode[3*m_own +: 3];
      case (m)
        3'd1: exp_g = 1'b1;
        3'd2: exp_r = 1'b1;
        3'd3: exp_g = blink;
        3'd4: exp_r = blink;
        3'd5: begin exp_g = !blink; exp_r = blink; end
        3'd6: begin exp_g = 1'b1; exp_r = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("green", 32'(led_green), 32'(exp_g));
    chk("red",   32'(led_red),   32'(exp_r));
    chk("blue",  32'(led_blue),  32'(exp_b));
    chk("tick",  32'(tick),      32'(exp_t));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_leds"},  32'({led_green, led_red, led_blue}), 32'd0);
    chk({tag, "_tick"},  32'(tick), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; mode = '0;
    E = 0; m_own = -1; m_gT = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // idle heartbeat and tick cadence
    repeat (90) step();
    // single requester, solid green then amber
    mode[8:6] = 3'd1; req = 4'b0100;
    repeat (6) step();
    mode[8:6] = 3'd6;
    repeat (4) step();
    req = '0;
    repeat (100) step();
    // two requesters, alternate pattern
    mode[5:3] = 3'd5; req = 4'b1010;
    repeat (100) step();
    req = '0;
    repeat (100) step();
    // owner drops during hold
    mode[11:9] = 3'd3; req = 4'b1000;
    repeat (20) step();
    req = '0;
    repeat (90) step();
    chk("idle_after_hold", 32'(grant), 32'd0);
    // higher priority arrives mid-hold
    mode[2:0] = 3'd2; req = 4'b0100;
    repeat (30) step();
    req = 4'b0101;
    repeat (80) step();
    req = '0;
    repeat (100) step();
    // asynchronous reset mid-grant
    req = 4'b0010;
    repeat (15) step();
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0; req = '0;
    E = 0; m_own = -1; m_gT = 0;
    repeat (25) step();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) req = NR'($urandom);
      if ($urandom_range(0, 39) == 0) mode = (3*NR)'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
